// File: rtl/tx_intf_pkg.sv
// Shared TX interface definitions.
// Holds the record word width, the marker values returned when the status
// queue is empty or an address is unmapped, and the layout of the status
// word {drop_cnt, reserved, level}.
package tx_intf_pkg;

    localparam int WORD_W = 32;

    // Values returned for head-record reads when no record is stored
    localparam logic [31:0] EMPTY_WORD0   = 32'hFFFF_FFFF;
    localparam logic [31:0] EMPTY_WORDN   = 32'h0000_0000;
    localparam logic [31:0] UNMAPPED_WORD = 32'h0000_0000;

    localparam int STAT_DROP_W = 16;
    localparam int STAT_LVL_W  = 9;

    // Status word field layout, MSB first
    typedef struct packed {
        logic [STAT_DROP_W-1:0] drop_cnt;
        logic [6:0]             rsvd;
        logic [STAT_LVL_W-1:0]  level;
    } tx_stat_word_t;

    function automatic logic [31:0] pack_status(input logic [STAT_DROP_W-1:0] drop,
                                                input logic [STAT_LVL_W-1:0]  lvl);
        tx_stat_word_t s;
        s.drop_cnt = drop;
        s.rsvd     = '0;
        s.level    = lvl;
        return s;
    endfunction

endpackage

// File: rtl/tx_status_queue_if.sv
// Bus bundle for tx_status_queue.
// Ports: push/rec_in (record capture), rd_en/rd_addr/rd_data (register
// read), level/irq (queue occupancy and interrupt).
// master = the side producing records and issuing reads; slave = the queue.
interface tx_status_queue_if #(
    parameter int NUM_WORD = 4,
    parameter int DEPTH    = 64
);
    import tx_intf_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                       push;
    logic [NUM_WORD*WORD_W-1:0] rec_in;
    logic                       rd_en;
    logic [4:0]                 rd_addr;
    logic [31:0]                rd_data;
    logic [LVL_W-1:0]           level;
    logic                       irq;

    modport master (output push, rec_in, rd_en, rd_addr,
                    input  rd_data, level, irq);
    modport slave  (input  push, rec_in, rd_en, rd_addr,
                    output rd_data, level, irq);
endinterface

// File: rtl/tx_status_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Ports: clk, we/waddr/wdata (write port), raddr/rdata (read port).
// Contents are not reset.
module tx_status_ram #(
    parameter  int WIDTH = 128,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tx_status_queue.sv
// TX status record queue.
// Records of NUM_WORD x 32 bits are captured on push, stored two cycles later
// and read back word by word through a register window starting at BASE_ADDR.
// Reading the last word pops the head record. The word after the window is a
// status word carrying the drop counter (cleared on read) and the level.
// Ports: clk, rstn (sync, active-low), bus (slave side of tx_status_queue_if).
module tx_status_queue
    import tx_intf_pkg::*;
#(
    parameter int         NUM_WORD   = 4,
    parameter int         DEPTH      = 64,
    parameter logic [4:0] BASE_ADDR  = 5'h16,
    parameter int         IRQ_THRESH = 1
) (
    input  logic              clk,
    input  logic              rstn,
    tx_status_queue_if.slave  bus
);
    localparam int               REC_W    = NUM_WORD * WORD_W;
    localparam int               AW       = $clog2(DEPTH);
    localparam int               LVL_W    = AW + 1;
    localparam logic [5:0]       BASE6    = {1'b0, BASE_ADDR};
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] IRQ_LVL  = LVL_W'(IRQ_THRESH);

    logic                   push_p1_q, push_p1_d;
    logic [REC_W-1:0]       rec_p1_q, rec_p1_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [STAT_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                   irq_q, irq_d;
    logic [31:0]            rd_data_q, rd_data_d;

    logic [REC_W-1:0] head_rec;
    logic [5:0]       off;
    logic             in_range, hit_word, hit_status;
    logic             empty, full, pop, store, drop;
    logic [31:0]      rd_word;

    tx_status_ram #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata (rec_p1_q),
        .raddr (rd_ptr_q),
        .rdata (head_rec)
    );

    always_comb begin
        push_p1_d = bus.push;
        rec_p1_d  = bus.rec_in;

        // Offset into the register window; in_range guards the wrapped case
        off        = {1'b0, bus.rd_addr} - BASE6;
        in_range   = ({1'b0, bus.rd_addr} >= BASE6);
        hit_word   = in_range && (off < 6'(NUM_WORD));
        hit_status = in_range && (off == 6'(NUM_WORD));

        empty = (level_q == '0);
        full  = (level_q == FULL_LVL);
        pop   = bus.rd_en && in_range && (off == 6'(NUM_WORD - 1)) && !empty;
        // A pop in the same cycle frees the slot a full queue needs
        store = push_p1_q && (!full || pop);
        drop  = push_p1_q && full && !pop;

        wr_ptr_d = store ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({store, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // Reading the status word clears the count, but a drop landing in
        // the same cycle must still be counted
        drop_cnt_d = drop_cnt_q;
        if (bus.rd_en && hit_status) begin
            drop_cnt_d = drop ? STAT_DROP_W'(1) : '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + STAT_DROP_W'(1);
        end

        irq_d = (level_q >= IRQ_LVL);

        rd_word = UNMAPPED_WORD;
        if (hit_word) begin
            if (empty) begin
                rd_word = (off == 6'd0) ? EMPTY_WORD0 : EMPTY_WORDN;
            end else begin
                for (int k = 0; k < NUM_WORD; k++) begin
                    if (off == 6'(k)) rd_word = head_rec[k*WORD_W +: WORD_W];
                end
            end
        end else if (hit_status) begin
            rd_word = pack_status(drop_cnt_q, STAT_LVL_W'(level_q));
        end

        rd_data_d = bus.rd_en ? rd_word : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            push_p1_q  <= 1'b0;
            rec_p1_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            push_p1_q  <= push_p1_d;
            rec_p1_q   <= rec_p1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.level   = level_q;
    assign bus.irq     = irq_q;
endmodule

// File: tb/tb_tx_status_queue.sv
// Directed bench for tx_status_queue: instance A (DEPTH=64) covers empty
// reads, push/read/pop, overflow and full-with-pop; instance B (DEPTH=16)
// covers pointer wrap-around and reset in the middle of traffic.
module tb_tx_status_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn_a = 1'b0;
    logic         rstn_b = 1'b0;
    logic         sel    = 1'b0;   // 0: observe A, 1: observe B
    logic         push   = 1'b0;
    logic [127:0] rec_in = '0;
    logic         rd_en  = 1'b0;
    logic [4:0]   rd_addr = '0;

    int n_tests = 0;
    int n_fail  = 0;

    tx_status_queue_if #(.NUM_WORD(4), .DEPTH(64)) ifa ();
    tx_status_queue_if #(.NUM_WORD(4), .DEPTH(16)) ifb ();

    assign ifa.push = push;  assign ifa.rec_in = rec_in;
    assign ifa.rd_en = rd_en; assign ifa.rd_addr = rd_addr;
    assign ifb.push = push;  assign ifb.rec_in = rec_in;
    assign ifb.rd_en = rd_en; assign ifb.rd_addr = rd_addr;

    tx_status_queue #(.NUM_WORD(4), .DEPTH(64), .BASE_ADDR(5'h16), .IRQ_THRESH(1)) u_dut_a (
        .clk(clk), .rstn(rstn_a), .bus(ifa.slave));
    tx_status_queue #(.NUM_WORD(4), .DEPTH(16), .BASE_ADDR(5'h16), .IRQ_THRESH(1)) u_dut_b (
        .clk(clk), .rstn(rstn_b), .bus(ifb.slave));

    logic [31:0] rd_data;
    logic [8:0]  level;
    logic        irq;
    always_comb begin
        rd_data = sel ? ifb.rd_data : ifa.rd_data;
        level   = sel ? 9'(ifb.level) : 9'(ifa.level);
        irq     = sel ? ifb.irq : ifa.irq;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns #1 after the edge
    task automatic cyc(input logic p, input logic [127:0] r, input logic re, input logic [4:0] a);
        push = p; rec_in = r; rd_en = re; rd_addr = a;
        @(posedge clk); #1;
        push = 1'b0; rd_en = 1'b0;
    endtask

    function automatic logic [127:0] mk(input int i);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[k*32 +: 32] = 32'hC0DE_0000 + 32'(i * 16 + k);
        return r;
    endfunction

    function automatic logic [31:0] wd(input int i, input int k);
        logic [127:0] r;
        r = mk(i);
        return r[k*32 +: 32];
    endfunction

    initial begin
        @(posedge clk); #1;
        cyc(0, '0, 0, 5'h0);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        rstn_a = 1'b1;

        // Empty reads straight after reset
        cyc(0, '0, 1, 5'h16); check("empty_w0", rd_data, 32'hFFFF_FFFF);
        cyc(0, '0, 1, 5'h19); check("empty_w3", rd_data, 32'h0);
        check("empty_level", 32'(level), 32'd0);
        cyc(0, '0, 1, 5'h1B); check("unmapped", rd_data, 32'h0);

        // Single push then read back
        cyc(1, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 5'h0);
        cyc(0, '0, 0, 5'h0);
        check("push_level", 32'(level), 32'd1);
        check("push_irq_lag", 32'(irq), 32'd0);
        cyc(0, '0, 1, 5'h16); check("rd_w0", rd_data, 32'h11);
        check("irq_up", 32'(irq), 32'd1);
        cyc(0, '0, 1, 5'h17); check("rd_w1", rd_data, 32'h22);
        cyc(0, '0, 1, 5'h18); check("rd_w2", rd_data, 32'h33);
        check("no_pop_level", 32'(level), 32'd1);
        cyc(0, '0, 1, 5'h19); check("rd_w3", rd_data, 32'h44);
        check("pop_level", 32'(level), 32'd0);
        cyc(0, '0, 0, 5'h0);
        check("irq_down", 32'(irq), 32'd0);

        // Overflow: 66 pushes into 64 slots
        for (int i = 0; i < 66; i++) cyc(1, mk(i), 0, 5'h0);
        cyc(0, '0, 0, 5'h0);
        cyc(0, '0, 0, 5'h0);
        check("ovf_level", 32'(level), 32'd64);
        cyc(0, '0, 1, 5'h1A); check("ovf_status", rd_data, 32'h0002_0040);
        cyc(0, '0, 1, 5'h1A); check("ovf_status_clr", rd_data, 32'h0000_0040);
        cyc(0, '0, 1, 5'h16); check("ovf_head", rd_data, wd(0, 0));

        // Full: store and pop land on the same edge
        cyc(1, mk(100), 0, 5'h0);
        cyc(0, '0, 1, 5'h19); check("full_pop_data", rd_data, wd(0, 3));
        check("full_pop_level", 32'(level), 32'd64);
        cyc(0, '0, 1, 5'h1A); check("full_pop_status", rd_data, 32'h0000_0040);
        for (int i = 1; i < 64; i++) begin
            cyc(0, '0, 1, 5'h19);
            check($sformatf("drain_%0d", i), rd_data, wd(i, 3));
        end
        cyc(0, '0, 1, 5'h16); check("tail_w0", rd_data, wd(100, 0));
        cyc(0, '0, 1, 5'h19); check("tail_w3", rd_data, wd(100, 3));
        check("tail_level", 32'(level), 32'd0);

        // Instance B: wrap-around with overlapping store/pop
        rstn_a = 1'b0; sel = 1'b1; rstn_b = 1'b1;
        cyc(0, '0, 0, 5'h0);
        cyc(1, mk(1000), 0, 5'h0);
        cyc(0, '0, 0, 5'h0);
        for (int i = 0; i < 200; i++) begin
            cyc(0, '0, 1, 5'h16); check($sformatf("wrap_%0d_w0", i), rd_data, wd(1000 + i, 0));
            cyc(0, '0, 1, 5'h17); check($sformatf("wrap_%0d_w1", i), rd_data, wd(1000 + i, 1));
            cyc(i < 199, mk(1001 + i), 1, 5'h18);
            check($sformatf("wrap_%0d_w2", i), rd_data, wd(1000 + i, 2));
            cyc(0, '0, 1, 5'h19); check($sformatf("wrap_%0d_w3", i), rd_data, wd(1000 + i, 3));
            check($sformatf("wrap_%0d_level", i), 32'(level), (i < 199) ? 32'd1 : 32'd0);
        end

        // Reset mid-operation with a store in flight
        for (int j = 0; j < 5; j++) cyc(1, mk(2000 + j), 0, 5'h0);
        check("pre_rst_level", 32'(level), 32'd4);
        check("pre_rst_irq", 32'(irq), 32'd1);
        rstn_b = 1'b0;
        cyc(0, '0, 0, 5'h0);
        rstn_b = 1'b1;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        cyc(0, '0, 1, 5'h16); check("post_rst_w0", rd_data, 32'hFFFF_FFFF);
        check("post_rst_level", 32'(level), 32'd0);
        cyc(0, '0, 1, 5'h16); check("post_rst_w0_again", rd_data, 32'hFFFF_FFFF);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
